ann_param_loader: RTL

- Writer-side counterpart of the ANN datapath's ROM/address-generator read path.
- Receives a byte stream from a host link (UART or JTAG bridge) with a valid/ready handshake, and assembles little-endian 32-bit IEEE-754 words.
- Writes those words into one of five parameter memories: input image, layer-01 weights, layer-01 biases, layer-12 weights, layer-12 biases.
- Tracks which regions are fully loaded, so inference can start only after every region has been written.

---
 rtl/ann_pkg.sv | 33 +++
 rtl/ann_param_loader_if.sv | 24 ++
 rtl/byte_to_word_packer.sv | 43 ++++
 rtl/ann_param_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared definitions for the ANN parameter memories: region ids, region sizes
// and the loader FSM encoding.
package ann_pkg;

    localparam int WORD_W    = 32;
    localparam int N_REGIONS = 5;

    localparam int WORDS_IMG = 64;
    localparam int WORDS_W01 = 512;
    localparam int WORDS_B01 = 8;
    localparam int WORDS_W12 = 16;
    localparam int WORDS_B12 = 2;

    typedef logic [2:0] region_t;

    localparam region_t REG_IMG = 3'd0;
    localparam region_t REG_W01 = 3'd1;
    localparam region_t REG_B01 = 3'd2;
    localparam region_t REG_W12 = 3'd3;
    localparam region_t REG_B12 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic is_region(input logic [7:0] hdr);
        return hdr < 8'(N_REGIONS);
    endfunction

endpackage

// File: rtl/ann_param_loader_if.sv
// Host byte stream plus parameter-memory write bus seen by the loader.
interface ann_param_loader_if
    import ann_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              wr_en;
    region_t           wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output s_data, s_valid,
        input  s_ready, wr_en, wr_sel, wr_addr, wr_data
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, wr_en, wr_sel, wr_addr, wr_data
    );
endinterface

// File: rtl/byte_to_word_packer.sv
// Little-endian byte-to-word assembler; word_ready marks the accept of lane 3,
// with word carrying the completed value in that same cycle.
module byte_to_word_packer
    import ann_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              accept,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    logic [1:0]  byte_cnt;
    logic [23:0] lanes;

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt <= 2'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Lane 3 is never stored: it is forwarded straight into the completed word.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (byte_cnt)
                2'd0:    lanes[7:0]   <= byte_in;
                2'd1:    lanes[15:8]  <= byte_in;
                2'd2:    lanes[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    assign word       = {byte_in, lanes};
    assign word_ready = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/ann_param_loader.sv
// Host-side writer for the ANN parameter memories: header byte selects a region,
// then little-endian words are written to consecutive addresses of that region.
module ann_param_loader
    import ann_pkg::*;
#(
    parameter int N_IMG  = WORDS_IMG,
    parameter int N_W01  = WORDS_W01,
    parameter int N_B01  = WORDS_B01,
    parameter int N_W12  = WORDS_W12,
    parameter int N_B12  = WORDS_B12,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ann_param_loader_if.slave    bus,
    output logic                 load_done,
    output logic [N_REGIONS-1:0] loaded_mask,
    output logic                 all_loaded,
    output logic                 hdr_err
);

    function automatic logic [ADDR_W-1:0] last_addr(input region_t id);
        case (id)
            REG_IMG: last_addr = ADDR_W'(N_IMG - 1);
            REG_W01: last_addr = ADDR_W'(N_W01 - 1);
            REG_B01: last_addr = ADDR_W'(N_B01 - 1);
            REG_W12: last_addr = ADDR_W'(N_W12 - 1);
            default: last_addr = ADDR_W'(N_B12 - 1);
        endcase
    endfunction

    state_t            state, state_n;
    logic              ready_q;
    logic              acc;
    logic              pk_accept, pk_clear, pk_ready;
    logic [WORD_W-1:0] pk_word;
    region_t           sel_q;
    logic [ADDR_W-1:0] word_cnt, limit_m1, addr_q;
    logic [WORD_W-1:0] data_q;

    assign acc       = bus.s_valid && ready_q;
    assign pk_accept = acc && (state == ST_LOAD);
    assign pk_clear  = acc && (state == ST_IDLE);

    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (bus.s_data),
        .accept     (pk_accept),
        .clear      (pk_clear),
        .word       (pk_word),
        .word_ready (pk_ready)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (acc && is_region(bus.s_data)) state_n = ST_LOAD;
            ST_LOAD:  if (pk_ready) state_n = ST_WRITE;
            ST_WRITE: state_n = (word_cnt == limit_m1) ? ST_DONE : ST_LOAD;
            default:  state_n = ST_IDLE;
        endcase
    end

    // s_ready is registered from the next state, so it drops in the WRITE cycle itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b0;
            sel_q       <= '0;
            word_cnt    <= '0;
            limit_m1    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            loaded_mask <= '0;
            hdr_err     <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == ST_IDLE) || (state_n == ST_LOAD);
            case (state)
                ST_IDLE: begin
                    if (acc) begin
                        if (is_region(bus.s_data)) begin
                            sel_q    <= bus.s_data[2:0];
                            limit_m1 <= last_addr(bus.s_data[2:0]);
                            word_cnt <= '0;
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (pk_ready) begin
                        data_q <= pk_word;
                        addr_q <= word_cnt;
                    end
                end
                ST_WRITE: begin
                    if (word_cnt != limit_m1) word_cnt <= word_cnt + 1'b1;
                end
                default: begin
                    loaded_mask <= loaded_mask | (N_REGIONS'(1) << sel_q);
                end
            endcase
        end
    end

    assign bus.s_ready = ready_q;
    assign bus.wr_en   = (state == ST_WRITE);
    assign bus.wr_sel  = sel_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign load_done   = (state == ST_DONE);
    assign all_loaded  = &loaded_mask;

endmodule
